apb_bridge_n: RTL and testbench
===============================

APB_BRIDGE_N -- requirements
Module: apb_bridge_n

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width of request, response and APB data buses.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter NUM_SLV, default 4, meaning number of APB slave ports (range 1..16).
REQ-004 SHALL have parameter SEL_LSB, default 8, meaning lowest address bit of the slave index field.
REQ-005 SHALL have parameter TIMEOUT, default 16, meaning maximum ACCESS cycles before abort (at least 2).
REQ-006 SHALL have a single clock and a synchronous, active-high reset: PCLK in 1 (clock, rising edge); PRESET in 1 (synchronous reset, active-high).
REQ-007 SHALL have these request ports: req_valid in 1 (request present); req_ready out 1 (request accepted this cycle); req_write in 1 (1 = write); req_addr in ADDR_W; req_wdata in DATA_W.
REQ-008 SHALL have these response ports: rsp_valid out 1 (one-cycle completion pulse); rsp_rdata out DATA_W; rsp_err out 1 (slave error, timeout or decode error).
REQ-009 SHALL have these APB ports: PSEL out NUM_SLV (one-hot); PENABLE out 1; PWRITE out 1; PADDR out ADDR_W; PWDATA out DATA_W.
REQ-010 SHALL have these slave return ports: PRDATA in NUM_SLV*DATA_W (slave k at bits [k*DATA_W +: DATA_W]); PREADY in NUM_SLV; PSLVERR in NUM_SLV.

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP, ACCESS and DECERR.
REQ-012 SHALL drive req_ready=1 only in IDLE; a request is accepted on the rising edge where IDLE and req_valid are both 1.
REQ-013 SHALL compute the slave index as req_addr[SEL_LSB +: clog2(NUM_SLV)], using one index bit when NUM_SLV=1.
REQ-014 SHALL, on accept, latch PADDR, PWDATA, PWRITE and the index, and hold them unchanged until the next accept.
REQ-015 SHALL move on accept to SETUP if the index is below NUM_SLV, otherwise to DECERR.
REQ-016 SHALL, in SETUP, assert PSEL[idx]=1 with PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-017 SHALL, in ACCESS, keep PSEL[idx]=1 and PENABLE=1, and sample only PREADY[idx], PSLVERR[idx] and the PRDATA slice idx.
REQ-018 SHALL complete ACCESS on the edge where PREADY[idx]=1, then:
- go to IDLE and deassert PSEL and PENABLE;
- in the following cycle pulse rsp_valid=1;
- set rsp_err=PSLVERR[idx];
- set rsp_rdata=PRDATA slice for reads, 0 for writes.
REQ-019 SHALL keep a wait counter that clears on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
REQ-020 SHALL treat an ACCESS cycle with PREADY[idx]=0 and wait counter = TIMEOUT-1 as a timeout:
- go to IDLE and deassert PSEL and PENABLE;
- in the following cycle pulse rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
REQ-021 SHALL, in DECERR, assert no PSEL bit for exactly one cycle, then go to IDLE and pulse rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
REQ-022 SHALL have zero-wait latency of accept edge → SETUP (cycle 1) → ACCESS (cycle 2) → rsp_valid and req_ready both 1 in cycle 3, i.e. one transfer per 3 cycles.
REQ-023 SHALL ignore PREADY, PSLVERR and PRDATA of unselected slaves, and ignore all slave inputs outside ACCESS.
REQ-024 SHALL keep PSEL one-hot or zero at all times, with PENABLE=1 only while PSEL is non-zero.
REQ-025 SHALL hold rsp_rdata and rsp_err stable when rsp_valid=0 until the next completion.
REQ-026 SHALL ignore req_valid and request data when not in IDLE; no request is queued.

Reset
REQ-027 SHALL, when PRESET=1 at a rising edge:
- set state IDLE;
- clear PSEL, PENABLE, PWRITE, PADDR, PWDATA;
- clear rsp_valid, rsp_rdata, rsp_err and the wait counter.
REQ-028 SHALL abandon any in-flight transfer when reset is asserted in SETUP, ACCESS or DECERR, and issue no rsp_valid for it.
REQ-029 SHALL hold req_ready=0 while PRESET=1, and set req_ready=1 from the first cycle after PRESET deasserts.

Structure
REQ-030 SHALL define the FSM state enumeration and the default parameter constants in shared package apb_pkg.
REQ-031 SHALL place index extraction and range check in sub-module apb_addr_decode, with input addr and outputs idx and in_range.
REQ-032 SHALL register all APB and response outputs; req_ready may be decoded directly from the state register.

Verification (NUM_SLV=4, SEL_LSB=8, TIMEOUT=16)
REQ-033 SHALL verify a zero-wait write: addr 0x0000_0204, data 0xDEAD_BEEF, slave 2 PREADY=1 → PSEL=4'b0100 in cycles 1-2, PENABLE=1 only in cycle 2, rsp_valid in cycle 3 with rsp_err=0.
REQ-034 SHALL verify a read with 3 wait states: addr 0x0000_0110, slave 1 PRDATA=0x1234_5678 → ACCESS lasts 4 cycles, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-035 SHALL verify a timeout: read addr 0x0000_0300 with slave 3 PREADY held 0 → exactly 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0.
REQ-036 SHALL verify slave error and decode error:
- slave error: slave 0 returns PREADY=1, PSLVERR=1 → rsp_err=1;
- decode error: NUM_SLV=3, addr 0x0000_0300 → no PSEL ever asserted, rsp_valid 2 cycles after accept with rsp_err=1.
REQ-037 SHALL verify back-to-back operation and reset: req_valid held high for 4 requests → accepts every 3 cycles; PRESET asserted during ACCESS → next cycle PSEL=0, PENABLE=0, rsp_valid=0, and no response is issued for the aborted transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB bridge: FSM encoding, default parameter
// values and a helper for sizing the slave index field.
package apb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_NUM_SLV = 4;
  localparam int DEF_SEL_LSB = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DECERR = 2'd3
  } apb_state_e;

  // A single slave still needs one index bit so the field is never zero-width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave index extraction and range check for the APB bridge.
// When NUM_SLV is not a power of two, the upper index codes decode to
// nothing and in_range drops so the bridge can report a decode error.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SEL_LSB = DEF_SEL_LSB,
  parameter int IDX_W   = idx_width(DEF_NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              in_range
);

  // Only the index field matters here; the rest of the address is carried
  // through to PADDR by the top level.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign idx      = addr[SEL_LSB +: IDX_W];
  assign in_range = (32'(idx) < NUM_SLV);

endmodule

// File: rtl/apb_bridge_n.sv
// Single-outstanding request-to-APB bridge fanning out to NUM_SLV slaves.
// Each request goes IDLE -> SETUP -> ACCESS -> IDLE (or IDLE -> DECERR ->
// IDLE for an unmapped index); the response is a registered one-cycle pulse
// in the cycle after the transfer ends, which is also the next IDLE cycle.
module apb_bridge_n
  import apb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SEL_LSB = DEF_SEL_LSB,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  // request side
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  // response side
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  // APB master side
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W = idx_width(NUM_SLV);
  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits for TIMEOUT >= 2.
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e         state;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic [IDX_W-1:0]   dec_idx;
  logic               dec_in_range;
  logic [NUM_SLV-1:0] dec_oh;

  logic [NUM_SLV-1:0]             slv_hit;
  logic [NUM_SLV-1:0][DATA_W-1:0] rd_masked;
  logic [DATA_W-1:0]              sel_rdata;
  logic                           sel_ready;
  logic                           sel_err;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB),
    .IDX_W   (IDX_W)
  ) u_dec (
    .addr     (req_addr),
    .idx      (dec_idx),
    .in_range (dec_in_range)
  );

  // One-hot select for the incoming request; all-zero when unmapped.
  always_comb begin
    dec_oh = '0;
    for (int k = 0; k < NUM_SLV; k++)
      dec_oh[k] = dec_in_range && (32'(dec_idx) == k);
  end

  // Per-slave gating of the return signals by the latched index, so that
  // unselected slaves can never influence the transfer.
  for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv
    assign slv_hit[k]   = (32'(idx_q) == k);
    assign rd_masked[k] = PRDATA[k*DATA_W +: DATA_W] & {DATA_W{slv_hit[k]}};
  end

  // OR-reduce the masked slices into the selected slave's read data.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++)
      sel_rdata = sel_rdata | rd_masked[k];
  end

  assign sel_ready = |(PREADY  & slv_hit);
  assign sel_err   = |(PSLVERR & slv_hit);

  // Reset is folded in so the request side stays closed for its duration.
  assign req_ready = (state == ST_IDLE) && !PRESET;

  // Bridge FSM with registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      wait_cnt  <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PWRITE <= req_write;
            idx_q  <= dec_idx;
            if (dec_in_range) begin
              PSEL  <= dec_oh;
              state <= ST_SETUP;
            end else begin
              state <= ST_DECERR;
            end
          end
        end
        ST_SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= PWRITE ? '0 : sel_rdata;
            state     <= ST_IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_n.sv
// Scoreboard bench for apb_bridge_n: a 4-slave instance with a configurable
// wait-state slave model, plus a 3-slave instance for decode errors.
module tb_apb_bridge_n;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic PRESET;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q4[$];
  exp_t q3[$];

  // ---------------- 4-slave DUT ----------------
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  apb_bridge_n #(.NUM_SLV(4), .SEL_LSB(8), .TIMEOUT(16)) dut (
    .PCLK(clk), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  // Slave model: slave k raises PREADY once cfg_wait[k] ACCESS cycles passed.
  int          cfg_wait [4];
  logic [31:0] cfg_rdata[4];
  logic [3:0]  cfg_err;
  int          acc_cnt = 0;

  always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  always_comb begin
    pready = '0;
    prdata = '0;
    for (int k = 0; k < 4; k++) begin
      pready[k]           = (acc_cnt >= cfg_wait[k]);
      prdata[k*32 +: 32]  = cfg_rdata[k];
    end
    pslverr = cfg_err;
  end

  // ---------------- 3-slave DUT (decode error) ----------------
  logic        d3_req_valid, d3_req_ready, d3_req_write;
  logic [31:0] d3_req_addr, d3_req_wdata;
  logic        d3_rsp_valid, d3_rsp_err;
  logic [31:0] d3_rsp_rdata;
  logic [2:0]  d3_psel;
  logic        d3_penable, d3_pwrite;
  logic [31:0] d3_paddr, d3_pwdata;
  logic [95:0] d3_prdata;
  logic [2:0]  d3_pready, d3_pslverr;

  assign d3_prdata  = {32'h3333_2222, 32'h3333_1111, 32'h3333_0000};
  assign d3_pready  = 3'b111;
  assign d3_pslverr = 3'b000;

  apb_bridge_n #(.NUM_SLV(3), .SEL_LSB(8), .TIMEOUT(16)) dut3 (
    .PCLK(clk), .PRESET(PRESET),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(d3_req_write),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
    .PSEL(d3_psel), .PENABLE(d3_penable), .PWRITE(d3_pwrite), .PADDR(d3_paddr),
    .PWDATA(d3_pwdata), .PRDATA(d3_prdata), .PREADY(d3_pready), .PSLVERR(d3_pslverr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a response.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q4.size() == 0) chk("rsp4_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("rsp4_rdata", rsp_rdata, e.rdata);
        chk("rsp4_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (d3_rsp_valid) begin
      if (q3.size() == 0) chk("rsp3_unexpected", 32'(d3_rsp_valid), 32'd0);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("rsp3_rdata", d3_rsp_rdata, e.rdata);
        chk("rsp3_err", 32'(d3_rsp_err), 32'(e.err));
      end
    end
  end

  // One transfer on the 4-slave DUT with cycle-level timing checks.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_sel, input int exp_acc,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    chk("xfer_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    q4.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    chk("setup_psel", 32'(psel), 32'(exp_sel));
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", 32'(pwrite), 32'(wr));
    chk("setup_pwdata", pwdata, wdata);
    @(negedge clk);
    n = 0;
    while (penable && n < 40) begin
      if (psel !== exp_sel) chk("access_psel", 32'(psel), 32'(exp_sel));
      n++;
      @(negedge clk);
    end
    chk("access_len", 32'(n), 32'(exp_acc));
    chk("done_psel", 32'(psel), 32'd0);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int acc[4];
    int n;
    PRESET = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    d3_req_valid = 0; d3_req_write = 0; d3_req_addr = '0; d3_req_wdata = '0;
    for (int k = 0; k < 4; k++) begin cfg_wait[k] = 0; cfg_rdata[k] = 32'h5A5A_0000 + k; end
    cfg_err = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_d3_ready", 32'(d3_req_ready), 32'd0);
    PRESET = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Zero-wait write to slave 2; write response data must be 0
    cfg_rdata[2] = 32'hAAAA_5555;
    run_xfer(1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 4'b0100, 1, 32'h0, 1'b0);

    // Read slave 1 with 3 wait states; other slaves ready and erroring
    cfg_wait[1] = 3; cfg_rdata[1] = 32'h1234_5678; cfg_err = 4'b1101;
    run_xfer(1'b0, 32'h0000_0110, 32'h0, 4'b0010, 4, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold_rsp_rdata", rsp_rdata, 32'h1234_5678);
    cfg_wait[1] = 0; cfg_err = '0;

    // Timeout on slave 3
    cfg_wait[3] = 1000;
    run_xfer(1'b0, 32'h0000_0300, 32'h0, 4'b1000, 16, 32'h0, 1'b1);
    cfg_wait[3] = 0;

    // Slave error on slave 0 (read data still returned)
    cfg_err = 4'b0001; cfg_rdata[0] = 32'hCAFE_F00D;
    run_xfer(1'b0, 32'h0000_0004, 32'h0, 4'b0001, 1, 32'hCAFE_F00D, 1'b1);
    cfg_err = '0;

    // Upper address bits ignored: 0x1234_0D00 -> index 1
    run_xfer(1'b1, 32'h1234_0D00, 32'h0BAD_F00D, 4'b0010, 1, 32'h0, 1'b0);

    // Decode error on 3-slave instance
    @(negedge clk);
    chk("dec_ready", 32'(d3_req_ready), 32'd1);
    d3_req_valid = 1'b1; d3_req_addr = 32'h0000_0300;
    q3.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    d3_req_valid = 1'b0;
    chk("dec_c1_psel", 32'(d3_psel), 32'd0);
    chk("dec_c1_rsp", 32'(d3_rsp_valid), 32'd0);
    @(negedge clk);
    chk("dec_c2_psel", 32'(d3_psel), 32'd0);
    chk("dec_c2_rsp", 32'(d3_rsp_valid), 32'd1);
    chk("dec_c2_ready", 32'(d3_req_ready), 32'd1);
    // Normal read on the 3-slave instance, slave 2
    d3_req_valid = 1'b1; d3_req_addr = 32'h0000_0200;
    q3.push_back('{rdata: 32'h3333_2222, err: 1'b0});
    @(negedge clk);
    d3_req_valid = 1'b0;
    chk("d3_setup_psel", 32'(d3_psel), 32'b100);
    repeat (2) @(negedge clk);
    chk("d3_rsp_cycle", 32'(d3_rsp_valid), 32'd1);

    // Back-to-back reads with req_valid held high
    for (int k = 0; k < 4; k++) cfg_rdata[k] = 32'h1000_0000 + k;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!req_ready && n < 10) begin @(negedge clk); n++; end
      if (n >= 10) chk("b2b_wait_ready", 32'(req_ready), 32'd1);
      req_addr = 32'(i) << 8;
      q4.push_back('{rdata: 32'h1000_0000 + 32'(i), err: 1'b0});
      acc[i] = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
    repeat (3) @(negedge clk);

    // Reset during ACCESS: transfer abandoned, no response
    cfg_wait[2] = 1000;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc_penable", 32'(penable), 32'd1);
    PRESET = 1'b1;
    @(negedge clk);
    chk("rst_acc_psel", 32'(psel), 32'd0);
    chk("rst_acc_penable0", 32'(penable), 32'd0);
    chk("rst_acc_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_acc_ready", 32'(req_ready), 32'd0);
    chk("rst_acc_paddr", paddr, 32'd0);
    PRESET = 1'b0;
    cfg_wait[2] = 0;
    repeat (4) @(negedge clk);
    chk("rst_acc_ready1", 32'(req_ready), 32'd1);
    chk("rst_acc_idle_psel", 32'(psel), 32'd0);

    repeat (3) @(negedge clk);
    chk("drain_q4", 32'(q4.size()), 32'd0);
    chk("drain_q3", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
